// File: rtl/network_config_pkg.sv
// Network-wide configuration shared by the source, core and sink blocks.
package network_config;

    localparam int NET_NUM_OUT = 4;

endpackage

// File: rtl/network_sink_pkg.sv
// Host-bound sink word encoding and FSM state codes for network_sink.
package sink_config;

    import network_config::*;

    typedef enum int unsigned {
        NOP         = 0,
        SPK         = 1,
        CYC         = 2,
        NUM_SNK_OPS = 3
    } snk_opcode_t;

    localparam int SNK_OPC_WIDTH = $clog2(NUM_SNK_OPS);
    localparam int IDX_WIDTH     = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EMIT_CYC = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;
    localparam logic [1:0] ST_EOC      = 2'd3;

endpackage

// File: rtl/network_sink_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a vector plus a found flag.
module lowest_set_idx #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/network_sink.sv
// Encodes per-cycle network output spike vectors into SPK/CYC host words,
// run-length compressing spike-free cycles into a single CYC count.
module network_sink
    import network_config::*;
    import sink_config::*;
#(
    parameter  int RUN_WIDTH     = 8,
    localparam int PAYLOAD_WIDTH = (IDX_WIDTH > RUN_WIDTH) ? IDX_WIDTH : RUN_WIDTH,
    localparam int SNK_WIDTH     = SNK_OPC_WIDTH + PAYLOAD_WIDTH
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic                 net_out [0:NET_NUM_OUT-1],
    input  logic                 flush,
    output logic                 snk_valid,
    input  logic                 snk_ready,
    output logic [SNK_WIDTH-1:0] snk
);

    localparam logic [RUN_WIDTH-1:0] RUN_MAX = {RUN_WIDTH{1'b1}};

    function automatic logic [SNK_WIDTH-1:0] spk_word(input logic [IDX_WIDTH-1:0] idx);
        return {SNK_OPC_WIDTH'(SPK), PAYLOAD_WIDTH'(idx)};
    endfunction

    function automatic logic [SNK_WIDTH-1:0] cyc_word(input logic [RUN_WIDTH-1:0] cnt);
        return {SNK_OPC_WIDTH'(CYC), PAYLOAD_WIDTH'(cnt)};
    endfunction

    logic [1:0]             state_r;
    logic [RUN_WIDTH-1:0]   count_r;
    logic [NET_NUM_OUT-1:0] vec_r;
    logic                   flush_pend_r;
    logic                   snk_valid_r;
    logic [SNK_WIDTH-1:0]   snk_r;

    logic [NET_NUM_OUT-1:0] net_vec_s;
    logic [NET_NUM_OUT-1:0] enc_in_s;
    logic [NET_NUM_OUT-1:0] enc_rest_s;
    logic [IDX_WIDTH-1:0]   enc_idx_s;
    logic                   enc_found_s;
    logic                   out_free_s;
    logic                   net_ready_s;
    logic                   accept_s;
    logic                   flush_req_s;

    // Flatten the incoming spike bits so bit i is output index i.
    always_comb begin
        net_vec_s = '0;
        for (int i = 0; i < NET_NUM_OUT; i++) begin
            net_vec_s[i] = net_out[i];
        end
    end

    // In IDLE the encoder looks at the arriving vector so its first SPK is ready at once.
    always_comb begin
        out_free_s  = !snk_valid_r || snk_ready;
        net_ready_s = (state_r == ST_IDLE) && out_free_s;
        accept_s    = net_valid && net_ready_s;
        flush_req_s = flush || flush_pend_r;
        enc_in_s    = (state_r == ST_IDLE) ? net_vec_s : vec_r;
        enc_rest_s  = enc_in_s & ~(NET_NUM_OUT'(1'b1) << enc_idx_s);
    end

    lowest_set_idx #(
        .WIDTH (NET_NUM_OUT),
        .IDX_W (IDX_WIDTH)
    ) u_lowest_set_idx (
        .vec   (enc_in_s),
        .idx   (enc_idx_s),
        .found (enc_found_s)
    );

    // Word sequencer: the output register is reloaded only once the current word is free.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            vec_r        <= '0;
            flush_pend_r <= 1'b0;
            snk_valid_r  <= 1'b0;
            snk_r        <= '0;
        end else begin
            flush_pend_r <= flush_req_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && enc_found_s) begin
                        snk_valid_r <= 1'b1;
                        if (count_r != '0) begin
                            snk_r   <= cyc_word(count_r);
                            count_r <= '0;
                            vec_r   <= net_vec_s;
                            state_r <= ST_EMIT_CYC;
                        end else begin
                            snk_r   <= spk_word(enc_idx_s);
                            vec_r   <= enc_rest_s;
                            state_r <= ST_DRAIN;
                        end
                    end else if (accept_s && (count_r == RUN_MAX - RUN_WIDTH'(1))) begin
                        // The saturated count already reports the run, so a coincident flush is absorbed.
                        snk_r        <= cyc_word(RUN_MAX);
                        snk_valid_r  <= 1'b1;
                        count_r      <= '0;
                        flush_pend_r <= 1'b0;
                        state_r      <= ST_EMIT_CYC;
                    end else if (accept_s) begin
                        count_r     <= count_r + RUN_WIDTH'(1);
                        snk_valid_r <= 1'b0;
                    end else if (out_free_s && flush_req_s) begin
                        snk_r        <= cyc_word(count_r);
                        snk_valid_r  <= 1'b1;
                        count_r      <= '0;
                        flush_pend_r <= 1'b0;
                        state_r      <= ST_EMIT_CYC;
                    end else if (out_free_s) begin
                        snk_valid_r <= 1'b0;
                    end
                end
                ST_EMIT_CYC: begin
                    if (out_free_s && enc_found_s) begin
                        snk_r   <= spk_word(enc_idx_s);
                        vec_r   <= enc_rest_s;
                        state_r <= ST_DRAIN;
                    end else if (out_free_s) begin
                        snk_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (out_free_s && enc_found_s) begin
                        snk_r <= spk_word(enc_idx_s);
                        vec_r <= enc_rest_s;
                    end else if (out_free_s) begin
                        snk_r   <= cyc_word(RUN_WIDTH'(1));
                        state_r <= ST_EOC;
                    end
                end
                ST_EOC: begin
                    if (out_free_s) begin
                        snk_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    snk_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign net_ready = net_ready_s;
    assign snk_valid = snk_valid_r;
    assign snk       = snk_r;

endmodule

// File: doc/network_sink.md
Name: network_sink

Overview:
- Output-side counterpart of the dispatch source. Receives per-cycle network output spike vectors and encodes them into a stream of host-bound words.
- Each fired output becomes one SPK word. Each network cycle boundary becomes a CYC word.
- Runs of spike-free cycles are run-length compressed into a single CYC word carrying the cycle count.
- Sits between the network core and the host transmit path. The flush request comes from the source's decode (DEC) indication.

Parameters:
- RUN_WIDTH, 8: width of the CYC cycle-count field; maximum count is 2^RUN_WIDTH-1.
- NET_NUM_OUT (from network_config), no local default: number of network outputs.

Ports:
- clk  in  1  clock.
- arstn  in  1  reset; synchronous, active-low.
- net_valid  in  1  network output vector valid.
- net_ready  out  1  sink can accept a vector.
- net_out  in  NET_NUM_OUT x 1 (indexed [0:NET_NUM_OUT-1])  output spike bits for one cycle.
- flush  in  1  single-cycle request to emit pending empty-cycle count.
- snk_valid  out  1  output word valid.
- snk_ready  in  1  host accepts word.
- snk  out  SNK_WIDTH  word {opcode[SNK_OPC_WIDTH-1:0], payload[PAYLOAD_WIDTH-1:0]}.

Behaviour:
- Reset (arstn low at a clk edge):
  - snk_valid=0, snk=0, pending count=0, latched vector=0, flush-pending=0, state=IDLE.
  - net_ready=1 during and after reset.
  - Reset mid-drain discards all latched and pending data.
- Word formats:
  - SPK: payload = output index, zero-extended.
  - CYC: payload = cycle count, zero-extended to PAYLOAD_WIDTH.
  - NOP opcode is never emitted.
- Output handshake:
  - A word transfers on snk_valid && snk_ready.
  - snk and snk_valid are registered and held stable while snk_valid && !snk_ready.
  - Next word may be presented in the cycle after a transfer, giving one word/cycle throughput.
- net_ready = (state==IDLE) && !(snk_valid && !snk_ready).
- Accepting a vector (net_valid && net_ready):
  - Spike-free vector: count increments. If count reaches 2^RUN_WIDTH-1, move to EMIT_CYC with that count and reset count to 0.
  - Vector with any bit set: latch it. If count>0, emit CYC(count) first. Then go to DRAIN.
- States:
  - IDLE: accepting vectors.
  - EMIT_CYC: one CYC word with the captured count, then return to IDLE or go to DRAIN per the pending vector.
  - DRAIN: emit SPK words for set bits in ascending index order, clearing each bit as its word transfers. When the vector is empty, go to EOC.
  - EOC: emit CYC(1), then IDLE.
- Latency: the first word is valid the cycle after the accepting edge.
- flush:
  - Handled only in IDLE; otherwise it is held as flush-pending until IDLE.
  - Emits CYC(count) and resets count to 0.
  - With count=0 it emits CYC(0), the explicit "sink empty" marker.
  - flush coinciding with vector acceptance: the vector is processed first, then the flush.
  - Multiple flush pulses while pending collapse into one.
- Saturation wins over a simultaneous flush; a later flush with count 0 emits CYC(0).
- Output vector width 1: payload index width is 1 and the index is always 0.

Decomposition:
- Package sink_config imports network_config. It holds:
  - snk_opcode_t enum {NOP=0, SPK, CYC, NUM_SNK_OPS}
  - SNK_OPC_WIDTH = $clog2(NUM_SNK_OPS)
  - IDX_WIDTH = max($clog2(NET_NUM_OUT),1)
  - PAYLOAD_WIDTH = max(IDX_WIDTH, RUN_WIDTH)
  - SNK_WIDTH = SNK_OPC_WIDTH + PAYLOAD_WIDTH
  - state enum
- Because RUN_WIDTH is a module parameter, PAYLOAD_WIDTH and SNK_WIDTH that depend on it are derived in-module, or RUN_WIDTH is passed through the package config.
- Sub-module lowest_set_idx: combinational priority encoder returning the index and a found flag for the latched vector.

Test Plan (NET_NUM_OUT=4, RUN_WIDTH=4, so PAYLOAD_WIDTH=4, SNK_WIDTH=6):
- Reset with stimulus active -> snk_valid=0, snk=0, net_ready=1; first post-reset empty vector produces no word.
- net_out=4'b1010 for one cycle, snk_ready=1 -> SPK 1, SPK 3, CYC 1 on consecutive cycles; net_ready=0 until CYC transfers.
- Three empty vectors, then 4'b0001 -> CYC 3, SPK 0, CYC 1.
- 15 consecutive empty vectors -> CYC 15 emitted automatically; 16th empty vector, then flush -> CYC 1.
- net_out=4'b1111 with snk_ready toggling 0/1 -> snk stable while stalled; exactly SPK 0,1,2,3, CYC 1, no duplicates or drops.
- flush with count 0 -> CYC 0. Reset asserted during DRAIN of 4'b0110 after SPK 1 -> no SPK 2 after reset; count=0.
